// File: rtl/fetch_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_stage
// Purpose  : IF stage of the 5-stage RISC-V pipeline; owns the PC, fetches from
//            a combinational instruction memory and fills the IF/ID register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] c_mem_limit = 32'(MEM_WORDS);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc_plus4;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic        r_fetch_fault;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic        w_in_range;
    logic [31:0] w_fetched;
    logic        w_target_misaligned;

    logic [31:0] w_pc_next;
    logic [31:0] w_if_id_pc_next;
    logic [31:0] w_if_id_pc_plus4_next;
    logic [31:0] w_if_id_instr_next;
    logic        w_if_id_valid_next;
    logic        w_fault_next;
    logic [31:0] w_count_next;

    // The PC wraps naturally mod 2^32; range is judged on the word index only.
    assign w_pc_plus4          = r_pc + 32'd4;
    assign w_in_range          = ({2'b00, r_pc[31:2]} < c_mem_limit);
    assign w_fetched           = w_in_range ? imem_instr : NOP_INSTR;
    assign w_target_misaligned = (redirect_target[1:0] != 2'b00);

    always_comb begin
        w_pc_next             = r_pc;
        w_if_id_pc_next       = r_if_id_pc;
        w_if_id_pc_plus4_next = r_if_id_pc_plus4;
        w_if_id_instr_next    = r_if_id_instr;
        w_if_id_valid_next    = r_if_id_valid;
        w_fault_next          = r_fetch_fault;
        w_count_next          = r_fetch_count;

        if (redirect_valid) begin
            // Wrong-path fetch is dropped; pc fields of IF/ID keep old values.
            w_pc_next          = {redirect_target[31:2], 2'b00};
            w_if_id_instr_next = NOP_INSTR;
            w_if_id_valid_next = 1'b0;
            if (w_target_misaligned) begin
                w_fault_next = 1'b1;
            end
        end else if (flush) begin
            w_if_id_instr_next = NOP_INSTR;
            w_if_id_valid_next = 1'b0;
            if (!stall) begin
                w_pc_next = w_pc_plus4;
            end
        end else if (!stall) begin
            w_pc_next             = w_pc_plus4;
            w_if_id_pc_next       = r_pc;
            w_if_id_pc_plus4_next = w_pc_plus4;
            w_if_id_instr_next    = w_fetched;
            w_if_id_valid_next    = w_in_range;
            if (w_in_range) begin
                w_count_next = r_fetch_count + 32'd1;
            end else begin
                w_fault_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_if_id_pc       <= 32'd0;
            r_if_id_pc_plus4 <= 32'd4;
            r_if_id_instr    <= NOP_INSTR;
            r_if_id_valid    <= 1'b0;
            r_fetch_fault    <= 1'b0;
            r_fetch_count    <= 32'd0;
        end else begin
            r_pc             <= w_pc_next;
            r_if_id_pc       <= w_if_id_pc_next;
            r_if_id_pc_plus4 <= w_if_id_pc_plus4_next;
            r_if_id_instr    <= w_if_id_instr_next;
            r_if_id_valid    <= w_if_id_valid_next;
            r_fetch_fault    <= w_fault_next;
            r_fetch_count    <= w_count_next;
        end
    end

    assign imem_addr      = r_pc;
    assign if_id_pc       = r_if_id_pc;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_valid    = r_if_id_valid;
    assign fetch_fault    = r_fetch_fault;
    assign fetch_count    = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fetch_stage
// Purpose  : Directed plus randomized bench for fetch_stage against a
//            rule-level reference model of the IF stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int          WORDS = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc, m_ifpc, m_ifp4, m_instr, m_count;
    logic        m_valid, m_fault;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(WORDS),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory word k holds 0x0010_0093 + k for every address, even beyond the
    // modelled depth, so a DUT that forgets the range check is visible.
    function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
        return 32'h0010_0093 + (byte_addr >> 2);
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".addr"},  imem_addr,             m_pc);
        chk({tag, ".pc"},    if_id_pc,              m_ifpc);
        chk({tag, ".pc4"},   if_id_pc_plus4,        m_ifp4);
        chk({tag, ".instr"}, if_id_instr,           m_instr);
        chk({tag, ".valid"}, {31'd0, if_id_valid},  {31'd0, m_valid});
        chk({tag, ".fault"}, {31'd0, fetch_fault},  {31'd0, m_fault});
        chk({tag, ".count"}, fetch_count,           m_count);
    endtask

    // Model one clock edge from the stated priority rules.
    task automatic model_edge(input logic rst, input logic s, input logic f,
                              input logic rv, input logic [31:0] rt);
        bit in_range;
        if (rst) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_ifp4 = 32'h4;
            m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0; m_count = 32'h0;
        end else if (rv) begin
            m_pc = rt & ~32'h3;
            m_instr = NOP; m_valid = 1'b0;
            if (rt % 4 != 0) m_fault = 1'b1;
        end else if (f) begin
            m_instr = NOP; m_valid = 1'b0;
            if (!s) m_pc = m_pc + 32'd4;
        end else if (!s) begin
            in_range = (m_pc / 4) < WORDS;
            m_ifpc  = m_pc;
            m_ifp4  = m_pc + 32'd4;
            m_instr = in_range ? mem_word(m_pc) : NOP;
            m_valid = in_range;
            if (in_range) m_count = m_count + 32'd1;
            else          m_fault = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic s, input logic f,
                        input logic rv, input logic [31:0] rt);
        reset = rst; stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
        @(posedge clk);
        model_edge(rst, s, f, rv, rt);
        #1;
        chk_all(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;

        // reset held together with stall and redirect: reset wins
        step("rst", 1, 1, 0, 1, 32'h80);
        chk("rst.addr0", imem_addr, 32'h0);
        chk("rst.nop",   if_id_instr, NOP);

        // free run
        step("run1", 0, 0, 0, 0, 0);
        step("run2", 0, 0, 0, 0, 0);
        chk("run2.pc",    if_id_pc,    32'h4);
        chk("run2.instr", if_id_instr, 32'h0010_0094);
        chk("run2.addr",  imem_addr,   32'h8);

        // stall three cycles at pc = 8
        for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 0, 0);
        chk("stall.addr", imem_addr, 32'h8);
        chk("stall.cnt",  fetch_count, 32'd2);
        step("unstall", 0, 0, 0, 0, 0);
        chk("unstall.pc",    if_id_pc,    32'h8);
        chk("unstall.instr", if_id_instr, 32'h0010_0095);

        // redirect together with stall at pc = 12
        step("redir", 0, 1, 0, 1, 32'h40);
        chk("redir.addr",  imem_addr,   32'h40);
        chk("redir.instr", if_id_instr, NOP);
        step("redir_next", 0, 0, 0, 0, 0);
        chk("redir_next.pc", if_id_pc, 32'h40);

        // misaligned redirect, fault is sticky
        step("mis", 0, 0, 0, 1, 32'h42);
        chk("mis.addr",  imem_addr, 32'h40);
        chk("mis.fault", {31'd0, fetch_fault}, 32'd1);
        for (int i = 0; i < 3; i++) step("sticky", 0, 0, 0, 0, 0);

        // flush only at pc = 20
        step("pre_flush", 0, 0, 0, 1, 32'h14);
        step("flush", 0, 0, 1, 0, 0);
        chk("flush.addr", imem_addr, 32'h18);
        // flush with stall holds pc
        step("flush_st", 0, 1, 1, 0, 0);

        step("rst2", 1, 0, 0, 0, 0);
        chk("rst2.fault", {31'd0, fetch_fault}, 32'd0);

        // run off the end of memory
        step("toend", 0, 0, 0, 1, 32'h3F8);
        for (int i = 0; i < 4; i++) step("end", 0, 0, 0, 0, 0);
        chk("end.valid", {31'd0, if_id_valid}, 32'd0);
        chk("end.instr", if_id_instr, NOP);

        // pc wrap at the top of the address space
        step("towrap", 0, 0, 0, 1, 32'hFFFF_FFFC);
        step("wrap1", 0, 0, 0, 0, 0);
        chk("wrap.addr", imem_addr, 32'h0);
        step("wrap2", 0, 0, 0, 0, 0);

        // randomized control traffic
        for (int i = 0; i < 400; i++) begin
            logic r_rst, r_s, r_f, r_rv;
            logic [31:0] r_t;
            r_rst = ($urandom_range(0, 49) == 0);
            r_s   = ($urandom_range(0, 3) == 0);
            r_f   = ($urandom_range(0, 5) == 0);
            r_rv  = ($urandom_range(0, 7) == 0);
            r_t   = $urandom_range(0, 32'h480);
            if ($urandom_range(0, 15) == 0) r_t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            step("rnd", r_rst, r_s, r_f, r_rv, r_t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage RISC-V pipeline.
- Owns the program counter and drives the word-addressed instruction memory, which reads combinationally.
- Registers the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles hazard-unit stalls, flushes and EX-stage branch/jump redirects, and flags faulting fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_WORDS, 256, instruction memory depth in 32-bit words; used for out-of-range detection.
- NOP_INSTR, 32'h0000_0013, ADDI x0,x0,0; inserted on bubbles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  from hazard unit; hold PC and IF/ID
- flush  input  1  squash IF/ID contents (bubble)
- redirect_valid  input  1  from EX; taken branch or jump this cycle
- redirect_target  input  32  new PC for the redirect
- imem_addr  output  32  byte address to instruction memory
- imem_instr  input  32  instruction returned for imem_addr, same cycle
- if_id_pc  output  32  PC of the latched instruction
- if_id_pc_plus4  output  32  if_id_pc + 4, mod 2^32
- if_id_instr  output  32  latched instruction
- if_id_valid  output  1  IF/ID holds a real instruction
- fetch_fault  output  1  sticky; misaligned redirect or out-of-range fetch
- fetch_count  output  32  count of valid instructions latched into IF/ID

Behaviour:
- Clocking: single clock (clk). Reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
- Reset values:
  - pc = RESET_PC
  - if_id_pc = 0, if_id_pc_plus4 = 4
  - if_id_instr = NOP_INSTR, if_id_valid = 0
  - fetch_fault = 0, fetch_count = 0
- imem_addr = pc, combinational, no latency. The instruction at pc appears in IF/ID one cycle after pc is presented.
- Define in_range = (pc[31:2] < MEM_WORDS). Define fetched = in_range ? imem_instr : NOP_INSTR.
- Per-edge priority, highest first:
  1. reset: apply reset values.
  2. redirect_valid:
     - pc <= {redirect_target[31:2], 2'b00}.
     - IF/ID <= bubble (instr = NOP_INSTR, valid = 0, pc fields hold previous values). The wrong-path fetch is discarded.
     - If redirect_target[1:0] != 0, set fetch_fault.
     - Redirect overrides stall and flush.
  3. flush without redirect:
     - IF/ID <= bubble.
     - pc <= pc + 4 if stall = 0; otherwise pc holds.
  4. stall: pc, IF/ID and fetch_count all hold.
  5. Normal:
     - pc <= pc + 4.
     - if_id_pc <= pc, if_id_pc_plus4 <= pc + 4, if_id_instr <= fetched, if_id_valid <= in_range.
     - If !in_range, set fetch_fault.
- pc + 4 wraps mod 2^32: 32'hFFFF_FFFC -> 32'h0000_0000. No fault is raised by the wrap itself; range checking applies at the next fetch.
- fetch_count increments by 1 on each edge where IF/ID is loaded with if_id_valid = 1. Wraps from 32'hFFFF_FFFF to 0. Never increments on bubble, stall or reset edges.
- fetch_fault is sticky once set and is cleared only by reset.
- Reset asserted mid-stall or mid-redirect: reset wins. The first post-reset imem_addr is RESET_PC.
- Stall asserted for N cycles: outputs are bit-identical for all N cycles. On the first unstalled edge the instruction at the held pc is latched.

Test Plan:
- Reset then free-run, memory word k = 32'h0010_0093 + k: after reset, imem_addr = 0, 4, 8 on successive cycles. Cycle 2 gives if_id_pc = 4, if_id_instr = mem[1], if_id_valid = 1. After 5 edges, fetch_count = 5.
- Stall for 3 cycles at pc = 8: imem_addr stays 8; IF/ID keeps pc = 4 and mem[1]; fetch_count unchanged. Next edge latches pc = 8, mem[2].
- Redirect at pc = 12 with target 32'h40, simultaneous with stall: next imem_addr = 32'h40, if_id_valid = 0, if_id_instr = 32'h13. The following edge latches pc = 32'h40 with valid = 1.
- Redirect with target 32'h42: pc becomes 32'h40 and fetch_fault = 1. Fault stays set through later normal fetches and clears only on reset.
- Free-run to pc = 32'h400 (word 256 = MEM_WORDS): IF/ID gets NOP_INSTR with valid = 0, fetch_fault = 1, and fetch_count stops incrementing.
- Flush only, no stall, at pc = 20: IF/ID becomes a bubble; next imem_addr = 24; fetch_count unchanged on that edge.
